// File: rtl/csr_pkg.sv
// Shared machine-mode CSR definitions: addresses, bit positions, trap causes
// and the trap sequencer state encoding.
package csr_pkg;

  // CSR addresses
  localparam logic [11:0] MSTATUS = 12'h300;
  localparam logic [11:0] MIE     = 12'h304;
  localparam logic [11:0] MTVEC   = 12'h305;
  localparam logic [11:0] MEPC    = 12'h341;
  localparam logic [11:0] MCAUSE  = 12'h342;
  localparam logic [11:0] MIP     = 12'h344;

  // mstatus bit positions
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_HI   = 12;
  localparam int MPP_LO   = 11;

  // mie / mip bit positions
  localparam int MTIP = 7;
  localparam int MEIP = 11;

  // mcause values for the two supported interrupt sources
  localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

  typedef enum logic [2:0] {
    IDLE,
    TR_EPC,
    TR_CAUSE,
    TR_STAT,
    TR_JUMP,
    MRET_ST,
    MRET_JUMP
  } trap_state_e;

endpackage

// File: rtl/trap_target_calc.sv
// Trap vector target: direct mode jumps to the mtvec base, vectored mode
// (mtvec[1:0] == 2'b01) adds four bytes per cause number.
module trap_target_calc #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] mtvec,
  input  logic [3:0]    cause_lo,
  output logic [DW-1:0] target
);

  logic [DW-1:0] base;
  logic [DW-1:0] offset;

  // Base address with mode bits stripped; offset wraps naturally at DW bits.
  always_comb begin
    base   = {mtvec[DW-1:2], 2'b00};
    offset = DW'({cause_lo, 2'b00});
    target = (mtvec[1:0] == 2'b01) ? base + offset : base;
  end

endmodule

// File: rtl/irq_trap_ctrl.sv
// Interrupt trap sequencer. Accepts enabled timer/external interrupts, flushes
// and stalls the pipeline, writes mepc/mcause/mstatus through the shared CSR
// write port and redirects the PC; sequences mret the same way.
module irq_trap_ctrl
  import csr_pkg::*;
#(
  parameter int DW    = 32,
  parameter int ADDRW = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             t_intr_i,
  input  logic             e_intr_i,
  input  logic             instr_valid_i,
  input  logic [DW-1:0]    pc_i,
  input  logic             is_mret_i,
  input  logic [DW-1:0]    mstatus_i,
  input  logic [DW-1:0]    mie_i,
  input  logic [DW-1:0]    mtvec_i,
  input  logic [DW-1:0]    mepc_i,
  input  logic             core_we_i,
  input  logic [ADDRW-1:0] core_addr_i,
  input  logic [DW-1:0]    core_wdata_i,
  output logic             csr_we_o,
  output logic [ADDRW-1:0] csr_addr_o,
  output logic [DW-1:0]    csr_wdata_o,
  output logic             core_stall_o,
  output logic             flush_o,
  output logic             pc_load_o,
  output logic [DW-1:0]    pc_o,
  output logic             busy_o
);

  trap_state_e state_q, state_d;

  logic [DW-1:0]    epc_q;
  logic [DW-1:0]    cause_q;
  logic             flush_q;
  logic             pc_load_q;
  logic [DW-1:0]    pc_q;
  logic             busy_q;

  logic             pend_e;
  logic             pend_t;
  logic             accept;
  logic [DW-1:0]    cause_sel;
  logic [DW-1:0]    target;
  logic [DW-1:0]    stat_trap;
  logic [DW-1:0]    stat_mret;
  logic             we_d;
  logic [ADDRW-1:0] addr_d;
  logic [DW-1:0]    wdata_d;
  logic             load_d;
  logic [DW-1:0]    load_pc_d;

  // Only the MTIP and MEIP enable bits matter here; fold the rest away.
  logic unused_mie;
  assign unused_mie = ^{mie_i[DW-1:MEIP+1], mie_i[MEIP-1:MTIP+1], mie_i[MTIP-1:0]};

  trap_target_calc #(.DW(DW)) u_target (
    .mtvec    (mtvec_i),
    .cause_lo (cause_q[3:0]),
    .target   (target)
  );

  // Pending interrupt detection, external beats timer.
  always_comb begin
    pend_e    = e_intr_i & mie_i[MEIP] & mstatus_i[MIE_BIT];
    pend_t    = t_intr_i & mie_i[MTIP] & mstatus_i[MIE_BIT];
    cause_sel = pend_e ? DW'(CAUSE_EXT) : DW'(CAUSE_TIMER);
  end

  // New mstatus images for trap entry and for mret.
  always_comb begin
    stat_trap                 = mstatus_i;
    stat_trap[MPIE_BIT]       = mstatus_i[MIE_BIT];
    stat_trap[MIE_BIT]        = 1'b0;
    stat_trap[MPP_HI:MPP_LO]  = 2'b11;
    stat_mret                 = mstatus_i;
    stat_mret[MIE_BIT]        = mstatus_i[MPIE_BIT];
    stat_mret[MPIE_BIT]       = 1'b1;
    stat_mret[MPP_HI:MPP_LO]  = 2'b11;
  end

  // Next-state logic and CSR write-port arbitration.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // through the case leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    accept    = 1'b0;
    we_d      = 1'b0;
    addr_d    = core_addr_i;
    wdata_d   = core_wdata_i;
    load_d    = 1'b0;
    load_pc_d = pc_q;

    unique case (state_q)
      IDLE: begin
        we_d = core_we_i;
        if (is_mret_i) begin
          state_d = MRET_ST;
        end else if ((pend_e | pend_t) & instr_valid_i) begin
          // The instruction being interrupted is flushed, so its write is dropped.
          accept  = 1'b1;
          we_d    = 1'b0;
          state_d = TR_EPC;
        end
      end
      TR_EPC: begin
        we_d    = 1'b1;
        addr_d  = ADDRW'(MEPC);
        wdata_d = epc_q;
        state_d = TR_CAUSE;
      end
      TR_CAUSE: begin
        we_d    = 1'b1;
        addr_d  = ADDRW'(MCAUSE);
        wdata_d = cause_q;
        state_d = TR_STAT;
      end
      TR_STAT: begin
        we_d    = 1'b1;
        addr_d  = ADDRW'(MSTATUS);
        wdata_d = stat_trap;
        state_d = TR_JUMP;
      end
      TR_JUMP: begin
        load_d    = 1'b1;
        load_pc_d = target;
        state_d   = IDLE;
      end
      MRET_ST: begin
        we_d    = 1'b1;
        addr_d  = ADDRW'(MSTATUS);
        wdata_d = stat_mret;
        state_d = MRET_JUMP;
      end
      MRET_JUMP: begin
        load_d    = 1'b1;
        load_pc_d = mepc_i;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched trap context and registered pipeline-control outputs.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, independent of statement order.
    if (!rst_ni) begin
      state_q   <= IDLE;
      epc_q     <= '0;
      cause_q   <= '0;
      flush_q   <= 1'b0;
      pc_load_q <= 1'b0;
      pc_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (accept) begin
        epc_q   <= pc_i;
        cause_q <= cause_sel;
      end
      flush_q   <= accept;
      pc_load_q <= load_d;
      if (load_d) pc_q <= load_pc_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  // A reset arriving mid-sequence must not let the current step's write out.
  assign csr_we_o     = we_d & rst_ni;
  assign csr_addr_o   = addr_d;
  assign csr_wdata_o  = wdata_d;
  assign core_stall_o = (busy_q | accept) & rst_ni;
  assign flush_o      = flush_q;
  assign pc_load_o    = pc_load_q;
  assign pc_o         = pc_q;
  assign busy_o       = busy_q;

endmodule
